idli_sqi_arb_m: RTL and testbench
=================================

# idli_sqi_arb_m

Arbitrates between the instruction-fetch and load/store requesters for the single SQI SRAM port. Each granted request is sequenced as a complete SQI transaction: chip select, command, address, dummy, data. Data moves one nibble per cycle, matching the core's nibble-serial datapath. The block sits between the core's front end / execution unit and the top-level SQI pins.

## Interface
- `DUMMY_CYCLES`, default 2: turnaround nibbles between address and read data.
- `CS_GAP_CYCLES`, default 1: minimum cycles CS stays deasserted between transactions (≥1).
- `i_sqa_gck` in 1: clock.
- `i_sqa_rst` in 1: reset, asynchronous, active-high.
- `i_sqa_fetch_req` in 1: fetch read request; held until `o_sqa_fetch_done`.
- `i_sqa_fetch_addr` in 16: fetch word address.
- `o_sqa_fetch_gnt` out 1: one-cycle pulse, fetch transaction started.
- `o_sqa_fetch_done` out 1: one-cycle pulse with the final data nibble.
- `i_sqa_lsu_req` in 1: load/store request; held until `o_sqa_lsu_done`.
- `i_sqa_lsu_wr` in 1: 1 = write, 0 = read.
- `i_sqa_lsu_addr` in 16: load/store word address.
- `i_sqa_lsu_wdata` in 4: write nibble, valid whenever `o_sqa_lsu_wready` is high.
- `o_sqa_lsu_gnt` out 1: one-cycle pulse, LSU transaction started.
- `o_sqa_lsu_done` out 1: one-cycle pulse with the final data nibble.
- `o_sqa_lsu_wready` out 1: write nibble consumed this cycle.
- `o_sqa_rdata` out 4: read nibble, shared by both requesters.
- `o_sqa_rvalid` out 1: `o_sqa_rdata` valid; the owner is the last granted requester.
- `o_sqa_sck` out 1: SCK enable; high in every active bus cycle.
- `o_sqa_cs` out 1: chip select, active-low.
- `o_sqa_sio_oe` out 1: drive enable for SIO.
- `o_sqa_sio_out` out 4: SIO output nibble.
- `i_sqa_sio_in` in 4: SIO input nibble.

## Operation
- States:
  - IDLE: arbitrate.
  - CMD: 2 cycles.
  - ADDR: 6 cycles.
  - DUMMY: `DUMMY_CYCLES` cycles, reads only.
  - DATA: 4 cycles.
  - GAP: `CS_GAP_CYCLES` cycles.
- Transitions:
  - GAP → IDLE.
  - IDLE → CMD when any request is high.
- Requests are sampled only in IDLE. On grant, the chosen requester's address and `wr` are latched; later changes on those inputs are ignored.
- Command byte: 0x03 for read, 0x02 for write, upper nibble first.
- Address is 24 bits, `{7'b0, addr[15:0], 1'b0}` (byte address), sent MS nibble first.
- Data nibble order on the bus and to/from requesters: byte0[7:4], byte0[3:0], byte1[7:4], byte1[3:0]. The requester reorders.
- `o_sqa_sio_oe` is high in CMD, ADDR and write DATA, and low otherwise. `o_sqa_sio_out` is 0 when `oe` is low.
- Read DATA: `o_sqa_rdata = i_sqa_sio_in` combinationally, with `o_sqa_rvalid` high.
- Write DATA: `o_sqa_lsu_wready` is high and `i_sqa_lsu_wdata` drives `o_sqa_sio_out` combinationally.
- `o_sqa_cs` is low in CMD..DATA and high in IDLE/GAP. `o_sqa_sck` equals `!o_sqa_cs`.
- The nibble counter is 3 bits, cleared on every state entry.
- Requesters deassert `req` by the cycle after `done`; GAP guarantees that IDLE sees the deasserted value.
- Priority when both request in IDLE: see Configuration. A lone request is always granted.
- Reset mid-transaction: the state goes to IDLE immediately, `o_sqa_cs` goes high, and the transaction is lost. Requesters reissue after reset.

## Timing
- Reset values:
  - `o_sqa_cs` = 1.
  - All other outputs = 0.
  - State = IDLE.
  - Fairness pointer = fetch-next.
- Cycle t: request seen in IDLE. Cycle t+1: first CMD cycle, with `gnt` pulsed.
- Read, with default parameters:
  - Data nibbles at t+11..t+14.
  - `done` at t+14.
  - GAP at t+15.
  - IDLE at t+16.
- Write:
  - Data at t+9..t+12.
  - `done` at t+12.
  - IDLE at t+14.
- Minimum request-to-request spacing (back-to-back, both pending) is 16 cycles for a read and 14 for a write.
- `gnt`, `done`, `rvalid` and `wready` are never high for both requesters in the same cycle.

## Configuration
- `IDLI_SQI_ARB_FAIR_EN`:
  - Defined: two-way round-robin. A 1-bit pointer toggles to the other requester on each grant made while both were pending, so neither starves.
  - Undefined: fixed priority, LSU over fetch. The pointer is not implemented.

## Test plan
- Fetch read, addr 0x1234, SIO returns 0xA,0xB,0xC,0xD → address nibbles 0,0,2,4,6,8; `rdata` A,B,C,D at t+11..t+14; `fetch_done` at t+14.
- LSU write, addr 0x0001, `wdata` 5,6,7,8 → CMD nibbles 0,2; address 0,0,0,0,0,2; `oe` high throughout; SIO out 5,6,7,8; `done` at t+12; no DUMMY.
- Both requests held continuously for 3 transactions:
  - With FAIR_EN: grants alternate fetch, LSU, fetch.
  - Without FAIR_EN: LSU, LSU, LSU.
- Assert `i_sqa_rst` during ADDR → `cs` high and outputs zero in the same cycle; after release, a fresh request restarts at CMD.
- Change `i_sqa_fetch_addr` after `gnt` → bus address unchanged. `cs` stays high for `CS_GAP_CYCLES` between back-to-back transactions.

Source files
------------

// File: rtl/idli_sqi_arb_m.sv
// ============================================================================
// Module   : idli_sqi_arb_m
// Purpose  : Arbitrates fetch / load-store requesters onto one nibble-serial
//            SQI SRAM port. Optional macro IDLI_SQI_ARB_FAIR_EN selects
//            round-robin arbitration (default: fixed LSU-over-fetch priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idli_sqi_arb_m #(
    parameter int DUMMY_CYCLES  = 2,
    parameter int CS_GAP_CYCLES = 1
) (
    input  logic        i_sqa_gck,
    input  logic        i_sqa_rst,
    input  logic        i_sqa_fetch_req,
    input  logic [15:0] i_sqa_fetch_addr,
    output logic        o_sqa_fetch_gnt,
    output logic        o_sqa_fetch_done,
    input  logic        i_sqa_lsu_req,
    input  logic        i_sqa_lsu_wr,
    input  logic [15:0] i_sqa_lsu_addr,
    input  logic [3:0]  i_sqa_lsu_wdata,
    output logic        o_sqa_lsu_gnt,
    output logic        o_sqa_lsu_done,
    output logic        o_sqa_lsu_wready,
    output logic [3:0]  o_sqa_rdata,
    output logic        o_sqa_rvalid,
    output logic        o_sqa_sck,
    output logic        o_sqa_cs,
    output logic        o_sqa_sio_oe,
    output logic [3:0]  o_sqa_sio_out,
    input  logic [3:0]  i_sqa_sio_in
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);
    localparam logic [2:0] GAP_LAST   = 3'(CS_GAP_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [2:0]  cnt;
    logic        owner_lsu;
    logic        lat_wr;
    logic [15:0] lat_addr;
    logic        any_req;
    logic        grant_lsu;
    logic [23:0] byte_addr;
    logic [3:0]  addr_nib;

    assign any_req   = i_sqa_fetch_req | i_sqa_lsu_req;
    assign byte_addr = {7'b0, lat_addr, 1'b0};

`ifdef IDLI_SQI_ARB_FAIR_EN
    // ptr_lsu = 0 means fetch wins the next contested grant
    logic ptr_lsu;

    assign grant_lsu = (i_sqa_fetch_req & i_sqa_lsu_req) ? ptr_lsu : i_sqa_lsu_req;

    always_ff @(posedge i_sqa_gck or posedge i_sqa_rst) begin
        if (i_sqa_rst) begin
            ptr_lsu <= 1'b0;
        end else if (state == ST_IDLE && i_sqa_fetch_req && i_sqa_lsu_req) begin
            ptr_lsu <= ~ptr_lsu;
        end
    end
`else
    assign grant_lsu = i_sqa_lsu_req;
`endif

    always_ff @(posedge i_sqa_gck or posedge i_sqa_rst) begin
        if (i_sqa_rst) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? 3'd0 : cnt + 3'd1;
        end
    end

    // Owner, address and direction are frozen at grant time
    always_ff @(posedge i_sqa_gck or posedge i_sqa_rst) begin
        if (i_sqa_rst) begin
            owner_lsu <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= 16'h0000;
        end else if (state == ST_IDLE && any_req) begin
            owner_lsu <= grant_lsu;
            lat_wr    <= grant_lsu & i_sqa_lsu_wr;
            lat_addr  <= grant_lsu ? i_sqa_lsu_addr : i_sqa_fetch_addr;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (any_req) next_state = ST_CMD;
            ST_CMD:   if (cnt == 3'd1) next_state = ST_ADDR;
            ST_ADDR:  if (cnt == 3'd5) next_state = (lat_wr || DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
            ST_DUMMY: if (cnt == DUMMY_LAST) next_state = ST_DATA;
            ST_DATA:  if (cnt == 3'd3) next_state = ST_GAP;
            ST_GAP:   if (cnt == GAP_LAST) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        case (cnt)
            3'd0:    addr_nib = byte_addr[23:20];
            3'd1:    addr_nib = byte_addr[19:16];
            3'd2:    addr_nib = byte_addr[15:12];
            3'd3:    addr_nib = byte_addr[11:8];
            3'd4:    addr_nib = byte_addr[7:4];
            3'd5:    addr_nib = byte_addr[3:0];
            default: addr_nib = 4'h0;
        endcase
    end

    always_comb begin
        o_sqa_cs         = 1'b1;
        o_sqa_sio_oe     = 1'b0;
        o_sqa_sio_out    = 4'h0;
        o_sqa_rdata      = 4'h0;
        o_sqa_rvalid     = 1'b0;
        o_sqa_lsu_wready = 1'b0;
        o_sqa_fetch_gnt  = 1'b0;
        o_sqa_lsu_gnt    = 1'b0;
        o_sqa_fetch_done = 1'b0;
        o_sqa_lsu_done   = 1'b0;
        case (state)
            ST_CMD: begin
                o_sqa_cs        = 1'b0;
                o_sqa_sio_oe    = 1'b1;
                o_sqa_sio_out   = (cnt == 3'd0) ? 4'h0 : (lat_wr ? 4'h2 : 4'h3);
                o_sqa_fetch_gnt = (cnt == 3'd0) && !owner_lsu;
                o_sqa_lsu_gnt   = (cnt == 3'd0) && owner_lsu;
            end
            ST_ADDR: begin
                o_sqa_cs      = 1'b0;
                o_sqa_sio_oe  = 1'b1;
                o_sqa_sio_out = addr_nib;
            end
            ST_DUMMY: begin
                o_sqa_cs = 1'b0;
            end
            ST_DATA: begin
                o_sqa_cs = 1'b0;
                if (lat_wr) begin
                    o_sqa_sio_oe     = 1'b1;
                    o_sqa_sio_out    = i_sqa_lsu_wdata;
                    o_sqa_lsu_wready = 1'b1;
                end else begin
                    o_sqa_rvalid = 1'b1;
                    o_sqa_rdata  = i_sqa_sio_in;
                end
                o_sqa_fetch_done = (cnt == 3'd3) && !owner_lsu;
                o_sqa_lsu_done   = (cnt == 3'd3) && owner_lsu;
            end
            default: ;
        endcase
        o_sqa_sck = ~o_sqa_cs;
    end

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_arb_m.sv
// ============================================================================
// Module   : tb_idli_sqi_arb_m
// Purpose  : Directed self-checking bench for idli_sqi_arb_m.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idli_sqi_arb_m;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, lsu_req, lsu_wr;
    logic [15:0] fetch_addr, lsu_addr;
    logic [3:0]  lsu_wdata, sio_in;
    logic        fetch_gnt, fetch_done, lsu_gnt, lsu_done, lsu_wready;
    logic [3:0]  rdata, sio_out;
    logic        rvalid, sck, cs, sio_oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idli_sqi_arb_m dut (
        .i_sqa_gck        (clk),
        .i_sqa_rst        (rst),
        .i_sqa_fetch_req  (fetch_req),
        .i_sqa_fetch_addr (fetch_addr),
        .o_sqa_fetch_gnt  (fetch_gnt),
        .o_sqa_fetch_done (fetch_done),
        .i_sqa_lsu_req    (lsu_req),
        .i_sqa_lsu_wr     (lsu_wr),
        .i_sqa_lsu_addr   (lsu_addr),
        .i_sqa_lsu_wdata  (lsu_wdata),
        .o_sqa_lsu_gnt    (lsu_gnt),
        .o_sqa_lsu_done   (lsu_done),
        .o_sqa_lsu_wready (lsu_wready),
        .o_sqa_rdata      (rdata),
        .o_sqa_rvalid     (rvalid),
        .o_sqa_sck        (sck),
        .o_sqa_cs         (cs),
        .o_sqa_sio_oe     (sio_oe),
        .o_sqa_sio_out    (sio_out),
        .i_sqa_sio_in     (sio_in)
    );

    logic [16:0] obs;
    assign obs = {cs, sck, sio_oe, sio_out, rvalid, rdata,
                  fetch_gnt, fetch_done, lsu_gnt, lsu_done, lsu_wready};

    localparam logic [16:0] RESET_VEC = {1'b1, 16'h0000};

    function automatic logic [16:0] ev(input logic e_cs, input logic e_oe, input logic [3:0] e_out,
                                       input logic e_rv, input logic [3:0] e_rd,
                                       input logic e_fg, input logic e_fd,
                                       input logic e_lg, input logic e_ld, input logic e_wr);
        return {e_cs, ~e_cs, e_oe, e_out, e_rv, e_rd, e_fg, e_fd, e_lg, e_ld, e_wr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_held got %h expected %h", obs, RESET_VEC);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_released_idle got %h expected %h", obs, RESET_VEC);
        end
    endtask

    // One read transaction from the chosen requester; exp_nibs is the hand-computed byte address
    task automatic run_read(input logic use_lsu, input logic [15:0] addr,
                            input logic [23:0] exp_nibs, input logic [15:0] rd_nibs,
                            input string name);
        logic [16:0] exp;
        logic [3:0]  dn;
        tick();
        if (use_lsu) begin
            lsu_req = 1'b1; lsu_wr = 1'b0; lsu_addr = addr;
        end else begin
            fetch_req = 1'b1; fetch_addr = addr;
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            if (k == 2) begin
                fetch_addr = 16'hFFFF;
                lsu_addr   = 16'hFFFF;
            end
            dn     = (k >= 11 && k <= 14) ? rd_nibs[15 - 4*(k-11) -: 4] : 4'h0;
            sio_in = (k >= 11 && k <= 14) ? dn : 4'h9;
            #1;
            if (k == 1)
                exp = ev(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, !use_lsu, 1'b0, use_lsu, 1'b0, 1'b0);
            else if (k == 2)
                exp = ev(1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (k <= 8)
                exp = ev(1'b0, 1'b1, exp_nibs[23 - 4*(k-3) -: 4], 1'b0, 4'h0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (k <= 10)
                exp = ev(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (k <= 14)
                exp = ev(1'b0, 1'b0, 4'h0, 1'b1, dn, 1'b0, (k == 14) && !use_lsu,
                         1'b0, (k == 14) && use_lsu, 1'b0);
            else
                exp = RESET_VEC;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s k=%0d got %h expected %h", name, k, obs, exp);
            end
            if (k == 14) begin
                fetch_req = 1'b0;
                lsu_req   = 1'b0;
            end
        end
    endtask

    task automatic test_fetch_read();
        run_read(1'b0, 16'h1234, 24'h002468, 16'hABCD, "fetch_read");
    endtask

    task automatic test_lsu_write();
        logic [16:0] exp;
        logic [3:0]  wd;
        tick();
        lsu_req = 1'b1; lsu_wr = 1'b1; lsu_addr = 16'h0001;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            wd        = (k >= 9 && k <= 12) ? 4'(k - 4) : 4'h0;
            lsu_wdata = (k >= 9 && k <= 12) ? wd : 4'hE;
            #1;
            if (k == 1)
                exp = ev(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            else if (k == 2)
                exp = ev(1'b0, 1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (k <= 8)
                exp = ev(1'b0, 1'b1, (k == 8) ? 4'h2 : 4'h0, 1'b0, 4'h0,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (k <= 12)
                exp = ev(1'b0, 1'b1, wd, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, k == 12, 1'b1);
            else
                exp = RESET_VEC;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lsu_write k=%0d got %h expected %h", k, obs, exp);
            end
            if (k == 12) lsu_req = 1'b0;
        end
        lsu_wr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   pos, idx;
        logic own_lsu;
        logic [2:0] exp;
        tick();
        fetch_req = 1'b1; fetch_addr = 16'h0100;
        lsu_req   = 1'b1; lsu_wr = 1'b0; lsu_addr = 16'h0200;
        sio_in    = 4'h5;
        for (int k = 1; k <= 48; k++) begin
            tick();
            pos = (k - 1) % 16;
            idx = (k - 1) / 16;
`ifdef IDLI_SQI_ARB_FAIR_EN
            own_lsu = (idx == 1);
`else
            own_lsu = 1'b1;
`endif
            exp = {(pos == 0) && !own_lsu, (pos == 0) && own_lsu, pos >= 14};
            checks++;
            if ({fetch_gnt, lsu_gnt, cs} !== exp) begin
                errors++;
                $display("FAIL back_to_back k=%0d got %b expected %b (fetch_gnt,lsu_gnt,cs)",
                         k, {fetch_gnt, lsu_gnt, cs}, exp);
            end
            if (k == 47) begin
                fetch_req = 1'b0;
                lsu_req   = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        fetch_req = 1'b1; fetch_addr = 16'h1234;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_mid_addr got %h expected %h", obs, RESET_VEC);
        end
        fetch_req = 1'b0;
        repeat (2) tick();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_mid_held got %h expected %h", obs, RESET_VEC);
        end
        rst = 1'b0;
        run_read(1'b1, 16'h0010, 24'h000020, 16'h1234, "read_after_reset");
    endtask

    initial begin
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 16'h0000;
        lsu_req    = 1'b0;
        lsu_wr     = 1'b0;
        lsu_addr   = 16'h0000;
        lsu_wdata  = 4'h0;
        sio_in     = 4'h0;
        test_reset();
        test_fetch_read();
        test_lsu_write();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
